// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C receive-only slave: FSM states, default
// address and the R/W bit position inside the address byte.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h4C;
  localparam int         RW_BIT           = 0;

  // Only write transfers to our own address are acknowledged.
  function automatic logic addrMatch(input logic [7:0] addrByte,
                                     input logic [6:0] devAddr);
    return (addrByte[7:1] == devAddr) && (addrByte[RW_BIT] == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_slave_rx_if.sv
// Bus-side and consumer-side signals of the I2C receiver, bundled so the
// slave and its environment see the same directions from opposite modports.
interface i2c_slave_rx_if;

  logic       scl;
  logic       sda;
  logic       sda_pull;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       overrun;

  modport slave (
    input  scl, sda, rx_ready,
    output sda_pull, rx_data, rx_valid, busy, overrun
  );

  modport master (
    output scl, sda, rx_ready,
    input  sda_pull, rx_data, rx_valid, busy, overrun
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchroniser for one asynchronous bus line plus rise/fall detection on the
// synchronised value; reset fills the chain with 1 so an idle bus is assumed.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Receive-only I2C slave: acknowledges write transfers to DEV_ADDR and hands
// each data byte to a valid/ready consumer, NACKing bytes it cannot store.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input logic           clock,
  input logic           reset_n,
  i2c_slave_rx_if.slave bus
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;
  logic startDet, stopDet;

  i2c_state_e state_q;
  logic [2:0] bitCnt_q;
  logic [6:0] shift_q;
  logic [7:0] rxByte_d;
  logic [7:0] rxData_q;
  logic       rxValid_q;
  logic       sdaPull_q;
  logic       busy_q;
  logic       overrun_q;

  i2c_line_sync #(.STAGES(STAGES)) u_scl_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .line_i  (bus.scl),
    .level_o (sclLevel),
    .rise_o  (sclRise),
    .fall_o  (sclFall)
  );

  i2c_line_sync #(.STAGES(STAGES)) u_sda_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .line_i  (bus.sda),
    .level_o (sdaLevel),
    .rise_o  (sdaRise),
    .fall_o  (sdaFall)
  );

  assign startDet = sdaFall & sclLevel;
  assign stopDet  = sdaRise & sclLevel;

  // Byte as it stands once the bit currently on SDA is shifted in.
  assign rxByte_d = {shift_q, sdaLevel};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= 3'd0;
      shift_q   <= 7'd0;
      rxData_q  <= 8'h00;
      rxValid_q <= 1'b0;
      sdaPull_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rxValid_q && bus.rx_ready) begin
        rxValid_q <= 1'b0;
      end

      // START/STOP override any bit-level activity and release SDA at once.
      if (startDet) begin
        state_q   <= ADDR;
        bitCnt_q  <= 3'd0;
        sdaPull_q <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stopDet) begin
        state_q   <= IDLE;
        bitCnt_q  <= 3'd0;
        sdaPull_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (sclRise) begin
              shift_q  <= rxByte_d[6:0];
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                state_q <= addrMatch(rxByte_d, DEV_ADDR) ? ADDR_ACK : IGNORE;
              end
            end
          end

          // First SCL fall after the byte starts the ACK, the next ends it.
          ADDR_ACK, DATA_ACK: begin
            if (sclFall) begin
              if (!sdaPull_q) begin
                sdaPull_q <= 1'b1;
              end else begin
                sdaPull_q <= 1'b0;
                state_q   <= DATA;
              end
            end
          end

          DATA: begin
            if (sclRise) begin
              shift_q  <= rxByte_d[6:0];
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                if (!rxValid_q) begin
                  rxData_q  <= rxByte_d;
                  rxValid_q <= 1'b1;
                  state_q   <= DATA_ACK;
                end else begin
                  overrun_q <= 1'b1;
                  state_q   <= IGNORE;
                end
              end
            end
          end

          IDLE, IGNORE: begin
            sdaPull_q <= 1'b0;
          end

          default: begin
            state_q   <= IDLE;
            sdaPull_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_pull = sdaPull_q;
  assign bus.rx_data  = rxData_q;
  assign bus.rx_valid = rxValid_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: a bit-banged master with directed scenarios and
// random transfers scored against a byte-level model of the slave.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic masterSda = 1'b1;

  int total = 0;
  int bad = 0;

  int hsCount = 0, validCycles = 0, ovrCycles = 0, pullCycles = 0;
  int ignoreCycles = 0, busyCycles = 0, hsViolations = 0;
  bit prevHs = 1'b0;
  logic [7:0] gotQ[$];

  int baseHs, baseValid, baseOvr, basePull, baseIgnore, baseBusy;
  logic [7:0] txBuf[4];

  i2c_slave_rx_if bus();

  assign bus.sda = masterSda & ~bus.sda_pull;

  i2c_slave_rx #(.DEV_ADDR(7'h4C), .SYNC_STAGES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (bus.rx_valid && bus.rx_ready) begin
      gotQ.push_back(bus.rx_data);
      hsCount++;
    end
    if (prevHs && bus.rx_valid) hsViolations++;
    prevHs = bus.rx_valid && bus.rx_ready;
    if (bus.rx_valid) validCycles++;
    if (bus.overrun) ovrCycles++;
    if (bus.sda_pull) pullCycles++;
    if (bus.busy) busyCycles++;
    if (dut.state_q == IGNORE) ignoreCycles++;
  end

  initial begin
    #(80000 * 10);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expVal);
    total++;
    if (obs !== expVal) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expVal);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic mark();
    baseHs     = hsCount;
    baseValid  = validCycles;
    baseOvr    = ovrCycles;
    basePull   = pullCycles;
    baseIgnore = ignoreCycles;
    baseBusy   = busyCycles;
  endtask

  task automatic sendStart();
    masterSda = 1'b1; waitClk(Q);
    bus.scl   = 1'b1; waitClk(Q);
    masterSda = 1'b0; waitClk(Q);
    bus.scl   = 1'b0; waitClk(Q);
  endtask

  task automatic sendStop();
    masterSda = 1'b0; waitClk(Q);
    bus.scl   = 1'b1; waitClk(Q);
    masterSda = 1'b1; waitClk(2 * Q);
  endtask

  task automatic sendBit(input logic b);
    masterSda = b;    waitClk(Q);
    bus.scl   = 1'b1; waitClk(2 * Q);
    bus.scl   = 1'b0; waitClk(Q);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
    masterSda = 1'b1; waitClk(Q);
    bus.scl   = 1'b1; waitClk(Q);
    ack = ~bus.sda;   waitClk(Q);
    bus.scl   = 1'b0; waitClk(Q);
  endtask

  task automatic applyStimulus(input int n, input bit ready, output logic [3:0] acks);
    logic a;
    bus.rx_ready = ready;
    waitClk(2);
    acks = '0;
    sendStart();
    for (int i = 0; i < n; i++) begin
      sendByte(txBuf[i], a);
      acks[i] = a;
    end
    sendStop();
    waitClk(Q);
  endtask

  initial begin
    logic [3:0] acks, expAcks;
    logic a;
    logic [7:0] v;
    logic [7:0] expQ[$];
    logic [7:0] addr, pendData;
    bit pending, ready, live, found;
    int nd, ovrExp, baseIdx, n;

    bus.scl = 1'b1;
    bus.rx_ready = 1'b0;
    reset_n = 1'b0;
    waitClk(3);
    checkOutput("rst_sda_pull", bus.sda_pull, 0);
    checkOutput("rst_rx_valid", bus.rx_valid, 0);
    checkOutput("rst_rx_data", bus.rx_data, 8'h00);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_overrun", bus.overrun, 0);
    reset_n = 1'b1;
    waitClk(5);

    $display("[TB] write 0x99 to own address");
    txBuf[0] = 8'h98; txBuf[1] = 8'h99;
    mark();
    applyStimulus(2, 1'b1, acks);
    checkOutput("t1_acks", acks, 4'b0011);
    checkOutput("t1_rx_data", bus.rx_data, 8'h99);
    checkOutput("t1_valid_cycles", validCycles - baseValid, 1);
    checkOutput("t1_handshakes", hsCount - baseHs, 1);
    checkOutput("t1_busy_seen", (busyCycles - baseBusy) > 0, 1);
    checkOutput("t1_pull_seen", (pullCycles - basePull) > 0, 1);
    checkOutput("t1_busy_after_stop", bus.busy, 0);

    $display("[TB] foreign address");
    txBuf[0] = 8'hA0; txBuf[1] = 8'h99;
    mark();
    applyStimulus(2, 1'b1, acks);
    checkOutput("t2_acks", acks, 4'b0000);
    checkOutput("t2_pull_cycles", pullCycles - basePull, 0);
    checkOutput("t2_valid_cycles", validCycles - baseValid, 0);
    checkOutput("t2_ignore_seen", (ignoreCycles - baseIgnore) > 0, 1);

    $display("[TB] overrun with consumer stalled");
    txBuf[0] = 8'h98; txBuf[1] = 8'h11; txBuf[2] = 8'h22;
    mark();
    applyStimulus(3, 1'b0, acks);
    checkOutput("t3_acks", acks, 4'b0011);
    checkOutput("t3_rx_valid", bus.rx_valid, 1);
    checkOutput("t3_rx_data", bus.rx_data, 8'h11);
    checkOutput("t3_overrun_cycles", ovrCycles - baseOvr, 1);
    checkOutput("t3_handshakes", hsCount - baseHs, 0);
    bus.rx_ready = 1'b1;
    waitClk(4);
    checkOutput("t3_drain", hsCount - baseHs, 1);
    checkOutput("t3_valid_cleared", bus.rx_valid, 0);

    $display("[TB] repeated start mid byte");
    mark();
    bus.rx_ready = 1'b1;
    sendStart();
    sendByte(8'h98, a);
    checkOutput("t4_addr_ack", a, 1);
    v = 8'h5A;
    for (int i = 7; i >= 4; i--) sendBit(v[i]);
    sendStart();
    sendByte(8'h98, a);
    sendByte(8'h5A, a);
    checkOutput("t4_data_ack", a, 1);
    sendStop();
    waitClk(Q);
    checkOutput("t4_handshakes", hsCount - baseHs, 1);
    checkOutput("t4_rx_data", bus.rx_data, 8'h5A);

    $display("[TB] reset during address ACK");
    mark();
    sendStart();
    v = 8'h98;
    for (int i = 7; i >= 0; i--) sendBit(v[i]);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.sda_pull) found = 1'b1;
      else waitClk(1);
    end
    checkOutput("t5_pull_wait", found, 1);
    masterSda = 1'b1;
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("t5_pull_released", bus.sda_pull, 0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("t5_busy", bus.busy, 0);
    checkOutput("t5_rx_valid", bus.rx_valid, 0);
    checkOutput("t5_rx_data", bus.rx_data, 8'h00);
    checkOutput("t5_overrun", bus.overrun, 0);
    reset_n = 1'b1;
    waitClk(Q);
    sendBit(1'b1);
    sendByte(8'h55, a);
    sendStop();
    waitClk(Q);
    checkOutput("t5_after_ack", a, 0);
    checkOutput("t5_handshakes", hsCount - baseHs, 0);
    checkOutput("t5_valid_cycles", validCycles - baseValid, 0);

    $display("[TB] random transfers");
    baseIdx = gotQ.size();
    pending = 1'b0;
    pendData = 8'h00;
    for (int t = 0; t < 15; t++) begin
      ready = 1'($urandom_range(0, 1));
      if (ready && pending) begin
        expQ.push_back(pendData);
        pending = 1'b0;
      end
      addr = ($urandom_range(0, 1) == 1) ? 8'h98 : 8'($urandom_range(0, 255));
      nd = $urandom_range(1, 3);
      txBuf[0] = addr;
      for (int k = 1; k <= nd; k++) txBuf[k] = 8'($urandom_range(0, 255));

      live = ((addr >> 1) == 8'h4C) && (addr % 2 == 0);
      expAcks = '0;
      expAcks[0] = live;
      ovrExp = 0;
      for (int k = 1; k <= nd; k++) begin
        if (live) begin
          if (pending) begin
            ovrExp++;
            live = 1'b0;
          end else begin
            expAcks[k] = 1'b1;
            if (ready) expQ.push_back(txBuf[k]);
            else begin
              pending = 1'b1;
              pendData = txBuf[k];
            end
          end
        end
      end

      mark();
      applyStimulus(nd + 1, ready, acks);
      checkOutput("rnd_acks", acks, expAcks);
      checkOutput("rnd_overrun", ovrCycles - baseOvr, ovrExp);
    end
    bus.rx_ready = 1'b1;
    waitClk(4);
    if (pending) expQ.push_back(pendData);

    n = gotQ.size() - baseIdx;
    checkOutput("rnd_count", n, expQ.size());
    for (int i = 0; i < n && i < expQ.size(); i++) begin
      checkOutput("rnd_byte", gotQ[baseIdx + i], expQ[i]);
    end
    checkOutput("hs_then_clear", hsViolations, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
